exec_step_controller: RTL and testbench
=======================================

Name: exec_step_controller

Overview:
- Sequences pipeline advance for the debug-unit-driven MIPS core.
- Generates the per-cycle step enable consumed by the PC and every pipeline register.
- Accepts RUN / STEP / STOP commands from the debug unit, stops on a HALT retiring in WB, and keeps an executed-cycle counter readable over UART.
- Sits between the debug unit and the pipeline top.

Parameters:
NB_CNT, 32, width of executed-cycle counter
MAX_CYCLES, 1024, watchdog limit in RUN mode (used only with CYCLE_LIMIT_EN)

Ports:
i_clk  in  1  system clock, rising-edge
i_reset  in  1  asynchronous, active-low reset (0 = reset)
i_cmd_valid  in  1  command strobe from debug unit, 1 cycle
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
i_halt  in  1  HALT instruction in WB this cycle
i_clear  in  1  program reload: synchronous return to IDLE
o_ready  out  1  1 when in IDLE (RUN/STEP will be accepted)
o_step  out  1  pipeline/PC advance enable
o_step_done  out  1  1-cycle pulse after a STEP cycle completes
o_halted  out  1  sticky, program finished
o_pc_clear  out  1  1-cycle pulse, drives PC/pipeline synchronous reset
o_cycle_count  out  NB_CNT  cycles with o_step=1 since last clear

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE.
  - o_step, o_step_done, o_halted, o_pc_clear = 0.
  - o_cycle_count = 0.
  - o_ready = 1 once reset is released.
- States: IDLE, RUN, STEP, HALTED. All outputs are Moore/registered; o_step = (state==RUN)|(state==STEP).
- IDLE:
  - valid RUN -> RUN.
  - valid STEP -> STEP.
  - STOP/NOP -> stay in IDLE.
  - i_halt is ignored.
- STEP:
  - Exactly one cycle with o_step=1.
  - Next state is IDLE, or HALTED if i_halt=1 in that cycle.
  - o_step_done=1 in the following cycle, including when the next state is HALTED.
- RUN:
  - o_step=1 every cycle.
  - i_halt=1 -> HALTED. The halt cycle itself is still stepped; o_step=0 from the next cycle.
  - Valid STOP -> IDLE.
  - Halt and STOP in the same cycle: HALTED wins.
  - RUN/STEP commands are ignored.
- HALTED:
  - o_halted=1, o_step=0.
  - All commands are ignored; only i_clear leaves this state.
- i_clear (any state, synchronous):
  - next state=IDLE, o_halted=0, o_cycle_count=0.
  - o_pc_clear=1 for exactly one cycle, the cycle after i_clear.
  - i_clear has priority over every command and over i_halt.
- Commands arriving when not accepted are dropped. They are not queued.
- o_cycle_count increments by 1 on each edge where o_step=1, and saturates at all-ones (no wrap).
- Asserting reset mid-RUN returns to IDLE asynchronously; o_step drops immediately.

Optional Feature:
CYCLE_LIMIT_EN:
- With it:
  - Adds output o_timeout (1 bit, sticky, reset 0).
  - An internal RUN-cycle counter is zeroed on entry to RUN.
  - When the counter reaches MAX_CYCLES consecutive RUN cycles without halt or stop: state -> HALTED and o_timeout=1.
  - i_clear clears o_timeout.
  - i_halt on the same cycle as the limit: o_timeout stays 0.
- Without it: no o_timeout port, no counter, and RUN is unbounded.

Test Plan:
- Release reset; STEP at t0 -> o_step=1 for 1 cycle, o_step_done pulse next cycle, o_cycle_count=1, o_ready back to 1.
- RUN, then i_halt after 10 stepped cycles -> o_step=0 next cycle, o_halted=1, o_cycle_count=11. A following RUN is ignored.
- RUN then STOP after 5 cycles -> IDLE, o_cycle_count=5. A subsequent RUN resumes and the count continues from 5.
- STOP and i_halt same cycle in RUN -> HALTED. Then i_clear -> o_pc_clear pulse 1 cycle, count=0, o_halted=0, o_ready=1.
- Assert reset while in RUN -> o_step=0 without a clock edge, and all outputs take their reset values.
- With CYCLE_LIMIT_EN, MAX_CYCLES=8: RUN with no halt -> exactly 8 stepped cycles, then o_timeout=1 and o_halted=1.

Source files
------------

// File: rtl/exec_step_controller.sv
// rtl/exec_step_controller.sv - pipeline step sequencer driven by the debug unit
// Optional macro CYCLE_LIMIT_EN adds a RUN-mode watchdog and the o_timeout output.
module exec_step_controller #(
  parameter int NB_CNT     = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  input  logic              i_halt,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_step,
  output logic              o_step_done,
  output logic              o_halted,
  output logic              o_pc_clear,
`ifdef CYCLE_LIMIT_EN
  output logic              o_timeout,
`endif
  output logic [NB_CNT-1:0] o_cycle_count
);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              step_done_q, step_done_d;
  logic              pc_clear_q, pc_clear_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

`ifdef CYCLE_LIMIT_EN
  localparam int RUN_CNT_W = $clog2(MAX_CYCLES + 1);
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      step_done_q <= 1'b0;
      pc_clear_q  <= 1'b0;
      cnt_q       <= '0;
`ifdef CYCLE_LIMIT_EN
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
      pc_clear_q  <= pc_clear_d;
      cnt_q       <= cnt_d;
`ifdef CYCLE_LIMIT_EN
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    pc_clear_d  = i_clear;
    cnt_d       = cnt_q;
`ifdef CYCLE_LIMIT_EN
    run_cnt_d   = run_cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && i_cmd == CMD_RUN) begin
          state_d = ST_RUN;
`ifdef CYCLE_LIMIT_EN
          run_cnt_d = '0;
`endif
        end else if (i_cmd_valid && i_cmd == CMD_STEP) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        step_done_d = 1'b1;
        state_d     = i_halt ? ST_HALTED : ST_IDLE;
      end
      ST_RUN: begin
        // Halt outranks STOP, and STOP outranks the watchdog.
        if (i_halt) begin
          state_d = ST_HALTED;
        end else if (i_cmd_valid && i_cmd == CMD_STOP) begin
          state_d = ST_IDLE;
`ifdef CYCLE_LIMIT_EN
        end else if (run_cnt_q == RUN_CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_HALTED;
    endcase

    if ((state_q == ST_RUN || state_q == ST_STEP) && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (i_clear) begin
      state_d     = ST_IDLE;
      step_done_d = 1'b0;
      cnt_d       = '0;
`ifdef CYCLE_LIMIT_EN
      timeout_d   = 1'b0;
`endif
    end
  end

  assign o_ready       = (state_q == ST_IDLE);
  assign o_step        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_step_done   = step_done_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_pc_clear    = pc_clear_q;
  assign o_cycle_count = cnt_q;
`ifdef CYCLE_LIMIT_EN
  assign o_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_exec_step_controller.sv
// tb/tb_exec_step_controller.sv - directed bench for exec_step_controller
// Exercises the CYCLE_LIMIT_EN watchdog when that macro is defined.
module tb_exec_step_controller;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        halt;
  logic        clear;
  logic        ready;
  logic        step;
  logic        step_done;
  logic        halted;
  logic        pc_clear;
  logic [31:0] cycle_count;
`ifdef CYCLE_LIMIT_EN
  logic        timeout;
`endif

  int errors = 0;
  int checks = 0;

  exec_step_controller #(.NB_CNT(32), .MAX_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .i_halt       (halt),
    .i_clear      (clear),
    .o_ready      (ready),
    .o_step       (step),
    .o_step_done  (step_done),
    .o_halted     (halted),
    .o_pc_clear   (pc_clear),
`ifdef CYCLE_LIMIT_EN
    .o_timeout    (timeout),
`endif
    .o_cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle command strobe, returning at the negedge after the accepting edge.
  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    halt      = 1'b0;
    clear     = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_step_done", step_done, 0);
    check("rst_halted", halted, 0);
    check("rst_pc_clear", pc_clear, 0);
    check("rst_count", cycle_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1);

    // Single STEP
    send(2'b10);
    check("step_on", step, 1);
    check("step_ready", ready, 0);
    check("step_cnt0", cycle_count, 0);
    @(negedge clk);
    check("step_off", step, 0);
    check("step_done_pulse", step_done, 1);
    check("step_cnt1", cycle_count, 1);
    check("step_ready_back", ready, 1);
    @(negedge clk);
    check("step_done_low", step_done, 0);

    // Clear then RUN with halt on the 11th stepped cycle
    do_clear();
    check("clr_pc_clear", pc_clear, 1);
    check("clr_count", cycle_count, 0);
    @(negedge clk);
    check("clr_pc_clear_once", pc_clear, 0);
    send(2'b01);
    for (int i = 0; i < 10; i++) begin
      check("run_step", step, 1);
      @(negedge clk);
    end
    check("run_cnt10", cycle_count, 10);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_step_off", step, 0);
    check("halt_halted", halted, 1);
    check("halt_cnt11", cycle_count, 11);
    send(2'b01);
    @(negedge clk);
    check("halt_run_ignored", step, 0);
    check("halt_sticky", halted, 1);
    check("halt_cnt_hold", cycle_count, 11);

    // RUN then STOP after 5 cycles, then resume
    do_clear();
    send(2'b01);
    repeat (4) @(negedge clk);
    send(2'b11);
    check("stop_idle", ready, 1);
    check("stop_step_off", step, 0);
    check("stop_cnt5", cycle_count, 5);
    send(2'b01);
    repeat (2) @(negedge clk);
    send(2'b11);
    check("resume_cnt8", cycle_count, 8);
    check("resume_ready", ready, 1);

    // STOP and halt in the same RUN cycle
    send(2'b01);
    halt = 1'b1;
    send(2'b11);
    halt = 1'b0;
    check("stop_halt_halted", halted, 1);
    check("stop_halt_ready", ready, 0);
    check("stop_halt_cnt9", cycle_count, 9);
    do_clear();
    check("clr2_pc_clear", pc_clear, 1);
    check("clr2_count", cycle_count, 0);
    check("clr2_halted", halted, 0);
    check("clr2_ready", ready, 1);
    @(negedge clk);
    check("clr2_pc_clear_once", pc_clear, 0);

    // Asynchronous reset during RUN
    send(2'b01);
    @(negedge clk);
    check("arst_pre_step", step, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_step", step, 0);
    check("arst_count", cycle_count, 0);
    check("arst_halted", halted, 0);
    check("arst_step_done", step_done, 0);
    check("arst_pc_clear", pc_clear, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", ready, 1);

`ifdef CYCLE_LIMIT_EN
    // Watchdog: 8 stepped cycles then halt with timeout
    check("wd_timeout_rst", timeout, 0);
    send(2'b01);
    for (int i = 0; i < 8; i++) begin
      check("wd_step", step, 1);
      @(negedge clk);
    end
    check("wd_step_off", step, 0);
    check("wd_halted", halted, 1);
    check("wd_timeout", timeout, 1);
    check("wd_cnt8", cycle_count, 8);
    do_clear();
    check("wd_timeout_clr", timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
